// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the hysteresis debouncer.
// Build option: DEBOUNCER_SYNC_EN enables the input synchronizer in debouncer.
package debouncer_pkg;

  localparam int DEF_MAX_TH = 20;
  localparam int DEF_MIN_TH = 5;

  // Integrator counter width able to hold 0..max_th inclusive.
  function automatic int cnt_width(int max_th);
    return $clog2(max_th + 1);
  endfunction

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the CLK domain.
// Used by debouncer only when DEBOUNCER_SYNC_EN is defined.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; both stages clear on reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/debouncer.sv
// Hysteresis debouncer: saturating up/down integrator with upper/lower thresholds.
// Build option: define DEBOUNCER_SYNC_EN to pass 'in' through a two-flop synchronizer first.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int P_MAX_TH = DEF_MAX_TH,
  parameter int P_MIN_TH = DEF_MIN_TH
) (
  input  logic CLK,
  input  logic RST,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(P_MAX_TH);
  localparam logic [CW-1:0] MAX_C = CW'(P_MAX_TH);
  localparam logic [CW-1:0] MIN_C = CW'(P_MIN_TH);

  if ((P_MIN_TH >= P_MAX_TH) || (P_MAX_TH < 2) || (P_MIN_TH < 0)) begin : g_bad_params
    $error("debouncer: illegal thresholds P_MAX_TH=%0d P_MIN_TH=%0d", P_MAX_TH, P_MIN_TH);
  end

  logic          sample_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          out_next_s;

`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (in),
    .q   (sample_s)
  );
`else
  assign sample_s = in;
`endif

  // Integrator step and threshold decision; the band between thresholds holds 'out'.
  always_comb begin
    cnt_next_s = cnt_r;
    out_next_s = out;
    if (sample_s && (cnt_r < MAX_C)) begin
      cnt_next_s = cnt_r + CW'(1);
    end else if (!sample_s && (cnt_r != {CW{1'b0}})) begin
      cnt_next_s = cnt_r - CW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end

    if (cnt_next_s >= MAX_C) begin
      out_next_s = 1'b1;
    end else if (cnt_next_s <= MIN_C) begin
      out_next_s = 1'b0;
    end else begin
      out_next_s = out;
    end
  end

  // Counter, level and edge pulses, all registered together so pulses align with 'out'.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_r <= cnt_next_s;
      out   <= out_next_s;
      rise  <= out_next_s & ~out;
      fall  <= ~out_next_s & out;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer: stimulus queues expected rise/fall edges, a monitor checks them.
module tb_debouncer;

`ifdef DEBOUNCER_SYNC_EN
  localparam int LX = 2;
`else
  localparam int LX = 0;
`endif

  typedef struct {
    bit is_rise;
    int cyc;
  } ev_t;

  logic CLK;
  logic RST;
  logic in;
  logic out;
  logic rise;
  logic fall;

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  debouncer #(.P_MAX_TH(20), .P_MIN_TH(5)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .in   (in),
    .out  (out),
    .rise (rise),
    .fall (fall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_edge(input bit is_rise, input int delay);
    ev_t e;
    e.is_rise = is_rise;
    e.cyc     = cyc + delay;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the next queued expectation.
  always @(negedge CLK) begin
    ev_t e;
    if (!RST && (rise || fall)) begin
      tests++;
      if (rise && fall) begin
        fails++;
        $display("FAIL both_pulses: rise=1 fall=1 at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_edge: rise=%0b fall=%0b at cycle %0d, none expected", rise, fall, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((e.is_rise != rise) || (e.cyc != cyc)) begin
          fails++;
          $display("FAIL edge_match: got rise=%0b at cycle %0d, expected rise=%0b at cycle %0d",
                   rise, cyc, e.is_rise, e.cyc);
        end
      end
    end
  end

  initial begin
    RST = 1'b0;
    in  = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("reset_out", out, 1'b0);
    chk("reset_rise", rise, 1'b0);
    chk("reset_fall", fall, 1'b0);
    step(2);
    RST = 1'b0;

    // Clean press: out rises on the 20th edge, held 25 cycles, then falls on the 15th edge.
    in = 1'b1;
    expect_edge(1'b1, 20 + LX);
    step(19 + LX);
    chk("press_before_rise", out, 1'b0);
    step(1);
    chk("press_after_rise", out, 1'b1);
    step(5 - LX);
    in = 1'b0;
    expect_edge(1'b0, 15 + LX);
    step(14 + LX);
    chk("release_before_fall", out, 1'b1);
    step(1);
    chk("release_after_fall", out, 1'b0);
    step(10);

    // Glitch: 19 cycles high never asserts out, and the count drains back to 0.
    in = 1'b1;
    step(19);
    in = 1'b0;
    step(LX + 1);
    chk("glitch_no_rise", out, 1'b0);
    step(20);
    chk("glitch_drained", out, 1'b0);
    in = 1'b1;
    expect_edge(1'b1, 20 + LX);
    step(19 + LX);
    chk("after_glitch_before_rise", out, 1'b0);
    step(1);
    chk("after_glitch_rise", out, 1'b1);
    step(5);

    // Hysteresis: 14 low cycles from saturation stay above the lower threshold.
    in = 1'b0;
    step(14);
    in = 1'b1;
    step(LX);
    chk("hyst_hold_low_burst", out, 1'b1);
    step(20);
    chk("hyst_resaturated", out, 1'b1);

    // Chatter around cnt=10: no change in out, no pulses.
    in = 1'b0;
    step(10);
    for (int i = 0; i < 100; i++) begin
      in = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(1);
      if ((i % 10) == 9) chk("chatter_hold", out, 1'b1);
    end
    expect_edge(1'b0, 5 + LX);
    step(4 + LX);
    chk("chatter_exit_before_fall", out, 1'b1);
    step(1);
    chk("chatter_exit_fall", out, 1'b0);
    step(20);

    // Mid-operation reset with in=1 and out=1: clears without a clock edge, then restarts from 0.
    in = 1'b1;
    expect_edge(1'b1, 20 + LX);
    step(20 + LX);
    chk("pre_reset_out", out, 1'b1);
    step(3);
    #2 RST = 1'b1;
    #1;
    chk("async_reset_out", out, 1'b0);
    chk("async_reset_rise", rise, 1'b0);
    chk("async_reset_fall", fall, 1'b0);
    step(2);
    RST = 1'b0;
    expect_edge(1'b1, 20 + LX);
    step(19 + LX);
    chk("post_reset_before_rise", out, 1'b0);
    step(1);
    chk("post_reset_rise", out, 1'b1);
    step(5);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_edges: %0d expected edges never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
